// File: rtl/nios2_oci_dct_packer_if.sv
// Output word bus from the trace packer to the OCI trace sink.
// The packer drives the word, count and valid. The sink drives ready.
interface nios2_oci_dct_packer_if #(
    parameter int ATOM_W = 2,
    parameter int SLOTS  = 15,
    parameter int CNT_W  = 4
);
    logic [ATOM_W*SLOTS-1:0] dct_buffer;
    logic [CNT_W-1:0]        dct_count;
    logic                    dct_valid;
    logic                    dct_ready;

    modport master (output dct_buffer, output dct_count, output dct_valid, input dct_ready);
    modport slave  (input dct_buffer, input dct_count, input dct_valid, output dct_ready);
endinterface

// File: rtl/nios2_oci_dct_packer.sv
// Nios II OCI trace packer.
// Collects 2-bit trace atoms into 15-slot words and hands each word to the
// trace sink over valid/ready. It also sequences the end-of-test handshake
// (drain, final word, ended).
module nios2_oci_dct_packer #(
    parameter int ATOM_W = 2,
    parameter int SLOTS  = 15,
    parameter int CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  atom_valid,
    input  logic [ATOM_W-1:0]     atom,
    input  logic                  flush,
    input  logic                  end_req,
    nios2_oci_dct_packer_if.master dct,
    output logic                  overflow,
    output logic                  test_ending,
    output logic                  test_has_ended
);
    localparam int               BUF_W = ATOM_W * SLOTS;
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(SLOTS);

    typedef enum logic [1:0] {RUN, DRAIN, LAST, ENDED} state_t;

    state_t             state_q, state_d;
    logic [BUF_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   fill_q, fill_d;
    logic [BUF_W-1:0]   dct_buffer_q, dct_buffer_d;
    logic [CNT_W-1:0]   dct_count_q, dct_count_d;
    logic               dct_valid_q, dct_valid_d;
    logic               flush_pend_q, flush_pend_d;
    logic               overflow_q, overflow_d;
    logic               test_ending_q, test_ending_d;
    logic               test_has_ended_q, test_has_ended_d;

    logic               in_run, in_drain, out_free, hs, full, take, flush_eff, xfer;
    logic [BUF_W-1:0]   m_acc;
    logic [CNT_W-1:0]   m_fill;

    // Merge the incoming atom, decide on a transfer, and compute the next FSM state.
    always_comb begin
        in_run    = (state_q == RUN);
        in_drain  = (state_q == DRAIN);
        out_free  = !dct_valid_q || dct.dct_ready;
        hs        = dct_valid_q && dct.dct_ready;
        full      = (fill_q == FULL);
        take      = in_run && atom_valid && !full;

        // Merged word: the accumulator plus the atom accepted this cycle.
        m_acc  = acc_q;
        m_fill = fill_q;
        if (take) begin
            for (int i = 0; i < SLOTS; i++) begin
                if (fill_q == CNT_W'(i)) m_acc[i*ATOM_W +: ATOM_W] = atom;
            end
            m_fill = fill_q + CNT_W'(1);
        end

        // In DRAIN the flush is forced so a partial word always gets out.
        flush_eff = (in_run && (flush || flush_pend_q)) || in_drain;
        xfer      = (in_run || in_drain) && out_free &&
                    ((m_fill == FULL) || (flush_eff && (m_fill != '0)));

        acc_d        = m_acc;
        fill_d       = m_fill;
        flush_pend_d = flush_pend_q || (in_run && flush);
        // Drops happen only while a full accumulator waits behind a stalled output.
        overflow_d   = overflow_q || (in_run && atom_valid && full && !out_free);

        if (xfer) begin
            acc_d        = '0;
            fill_d       = '0;
            flush_pend_d = 1'b0;
            // When a full accumulator drains, the atom from the same cycle starts the next word.
            if (in_run && atom_valid && full) begin
                acc_d[ATOM_W-1:0] = atom;
                fill_d            = CNT_W'(1);
            end
        end

        dct_buffer_d = dct_buffer_q;
        dct_count_d  = dct_count_q;
        dct_valid_d  = dct_valid_q && !hs;
        if (xfer) begin
            dct_buffer_d = m_acc;
            dct_count_d  = m_fill;
            dct_valid_d  = 1'b1;
        end

        state_d = state_q;
        case (state_q)
            RUN:   if (end_req) state_d = DRAIN;
            DRAIN: begin
                if (fill_q != '0) begin
                    if (xfer) state_d = LAST;
                end else if (dct_valid_q && !hs) begin
                    // The word already waiting becomes the final one.
                    state_d = LAST;
                end else begin
                    // Nothing is left, or the last word is being taken right now.
                    state_d = ENDED;
                end
            end
            LAST:  if (hs) state_d = ENDED;
            default: ;
        endcase

        test_ending_d    = (state_d == LAST);
        test_has_ended_d = (state_d == ENDED);
    end

    // State registers, with a synchronous reset that throws away all pending work.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= RUN;
            acc_q            <= '0;
            fill_q           <= '0;
            dct_buffer_q     <= '0;
            dct_count_q      <= '0;
            dct_valid_q      <= 1'b0;
            flush_pend_q     <= 1'b0;
            overflow_q       <= 1'b0;
            test_ending_q    <= 1'b0;
            test_has_ended_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            acc_q            <= acc_d;
            fill_q           <= fill_d;
            dct_buffer_q     <= dct_buffer_d;
            dct_count_q      <= dct_count_d;
            dct_valid_q      <= dct_valid_d;
            flush_pend_q     <= flush_pend_d;
            overflow_q       <= overflow_d;
            test_ending_q    <= test_ending_d;
            test_has_ended_q <= test_has_ended_d;
        end
    end

    assign dct.dct_buffer = dct_buffer_q;
    assign dct.dct_count  = dct_count_q;
    assign dct.dct_valid  = dct_valid_q;
    assign overflow       = overflow_q;
    assign test_ending    = test_ending_q;
    assign test_has_ended = test_has_ended_q;
endmodule

// File: tb/tb_nios2_oci_dct_packer.sv
// Directed table-driven bench for nios2_oci_dct_packer.
// Each record is applied for one clock cycle. Checked records compare every
// output one cycle later, just after the rising edge.
module tb_nios2_oci_dct_packer;
    localparam int ATOM_W = 2;
    localparam int SLOTS  = 15;
    localparam int CNT_W  = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       atom_valid = 1'b0;
    logic [1:0] atom = '0;
    logic       flush = 1'b0;
    logic       end_req = 1'b0;
    logic       overflow, test_ending, test_has_ended;

    nios2_oci_dct_packer_if #(.ATOM_W(ATOM_W), .SLOTS(SLOTS), .CNT_W(CNT_W)) dct();

    nios2_oci_dct_packer #(.ATOM_W(ATOM_W), .SLOTS(SLOTS), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .atom_valid     (atom_valid),
        .atom           (atom),
        .flush          (flush),
        .end_req        (end_req),
        .dct            (dct.master),
        .overflow       (overflow),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        av;
        logic [1:0]  at;
        logic        fl;
        logic        er;
        logic        rdy;
        logic        chk;
        logic        ev;
        logic [3:0]  ec;
        logic [29:0] eb;
        logic        eo;
        logic        ete;
        logic        ehe;
    } vec_t;

    vec_t tbl[$];
    int   n_run  = 0;
    int   n_fail = 0;

    function automatic void add(input logic rst, av, input logic [1:0] at, input logic fl, er, rdy,
                                input logic chk, ev, input logic [3:0] ec, input logic [29:0] eb,
                                input logic eo, ete, ehe);
        vec_t t;
        t.rst = rst; t.av = av; t.at = at; t.fl = fl; t.er = er; t.rdy = rdy;
        t.chk = chk; t.ev = ev; t.ec = ec; t.eb = eb; t.eo = eo; t.ete = ete; t.ehe = ehe;
        tbl.push_back(t);
    endfunction

    function automatic void drv(input logic rst, av, input logic [1:0] at, input logic fl, er, rdy);
        add(rst, av, at, fl, er, rdy, 1'b0, 1'b0, 4'd0, 30'd0, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic chk(input int idx, input string what, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL vec%0d %s: got %0h expected %0h", idx, what, act, exp);
        end
    endtask

    initial begin
        // Reset state.
        add(1,0,0,0,0,1, 1, 0,0,30'h0, 0,0,0);

        // 15 atoms i%4 with ready high. Slot i holds i mod 4, which gives 0xE4 per byte,
        // so the 30-bit word is 24E4E4E4. A second word of all 01 follows back-to-back.
        for (int i = 0; i < 14; i++) drv(0,1,2'(i % 4),0,0,1);
        add(0,1,2'd2,0,0,1, 1, 1,15,30'h24E4E4E4, 0,0,0);
        add(0,1,2'd1,0,0,1, 1, 0,15,30'h24E4E4E4, 0,0,0);
        for (int i = 1; i < 14; i++) drv(0,1,2'd1,0,0,1);
        add(0,1,2'd1,0,0,1, 1, 1,15,30'h15555555, 0,0,0);
        add(0,0,0,0,0,1,    1, 0,15,30'h15555555, 0,0,0);

        // Five atoms of 11 then flush; the next atom starts slot 0; a pending flush waits for an atom.
        drv(1,0,0,0,0,1);
        for (int i = 0; i < 4; i++) drv(0,1,2'd3,0,0,1);
        add(0,1,2'd3,0,0,1, 1, 0,0,30'h0, 0,0,0);
        add(0,0,0,1,0,1,    1, 1,5,30'h3FF, 0,0,0);
        add(0,1,2'd1,1,0,1, 1, 1,1,30'h1, 0,0,0);
        add(0,0,0,1,0,1,    1, 0,1,30'h1, 0,0,0);
        add(0,1,2'd2,0,0,1, 1, 1,1,30'h2, 0,0,0);
        add(0,0,0,0,0,0,    1, 1,1,30'h2, 0,0,0);
        add(0,0,0,0,0,1,    1, 0,1,30'h2, 0,0,0);

        // Stall: 32 atoms with ready low. Word 1 is held, the accumulator fills at atom 30, and atoms 31-32 are dropped.
        drv(1,0,0,0,0,0);
        for (int i = 0; i < 14; i++) drv(0,1,2'd1,0,0,0);
        add(0,1,2'd1,0,0,0, 1, 1,15,30'h15555555, 0,0,0);
        for (int i = 0; i < 14; i++) drv(0,1,2'd2,0,0,0);
        add(0,1,2'd2,0,0,0, 1, 1,15,30'h15555555, 0,0,0);
        add(0,1,2'd3,0,0,0, 1, 1,15,30'h15555555, 1,0,0);
        add(0,1,2'd3,0,0,0, 1, 1,15,30'h15555555, 1,0,0);
        // Ready rises with an atom: word 2 loads, and the atom lands in slot 0 of a fresh accumulator.
        add(0,1,2'd3,0,0,1, 1, 1,15,30'h2AAAAAAA, 1,0,0);
        add(0,0,0,1,0,1,    1, 1,1,30'h3, 1,0,0);
        add(0,0,0,0,0,1,    1, 0,1,30'h3, 1,0,0);

        // Reset while stalled with overflow set; the accumulator must be discarded as well.
        drv(1,0,0,0,0,0);
        for (int i = 0; i < 30; i++) drv(0,1,2'd1,0,0,0);
        add(0,1,2'd1,0,0,0, 1, 1,15,30'h15555555, 1,0,0);
        add(1,0,0,0,0,0,    1, 0,0,30'h0, 0,0,0);
        add(0,0,0,1,0,1,    1, 0,0,30'h0, 0,0,0);

        // Seven atoms then end_req. An atom during DRAIN is ignored, and test_ending holds while ready is low.
        drv(1,0,0,0,0,1);
        for (int i = 0; i < 6; i++) drv(0,1,2'd2,0,0,1);
        add(0,1,2'd2,0,0,1, 1, 0,0,30'h0, 0,0,0);
        add(0,0,0,0,1,1,    1, 0,0,30'h0, 0,0,0);
        add(0,1,2'd3,0,0,0, 1, 1,7,30'h2AAA, 0,1,0);
        add(0,0,0,1,0,0,    1, 1,7,30'h2AAA, 0,1,0);
        add(0,0,0,0,0,1,    1, 0,7,30'h2AAA, 0,0,1);
        for (int i = 0; i < 16; i++) drv(0,1,2'(i % 4),1,1,1);
        add(0,1,2'd1,1,1,1, 1, 0,7,30'h2AAA, 0,0,1);

        // end_req with nothing buffered: ended two cycles later and no word.
        drv(1,0,0,0,0,1);
        add(0,0,0,0,1,1, 1, 0,0,30'h0, 0,0,0);
        add(0,0,0,0,0,1, 1, 0,0,30'h0, 0,0,1);

        // end_req with an empty accumulator but a stalled word: that word is final.
        drv(1,0,0,0,0,0);
        drv(0,1,2'd1,0,0,0);
        add(0,1,2'd1,0,0,0, 1, 0,0,30'h0, 0,0,0);
        add(0,0,0,1,0,0,    1, 1,2,30'h5, 0,0,0);
        add(0,0,0,0,1,0,    1, 1,2,30'h5, 0,0,0);
        add(0,0,0,0,0,0,    1, 1,2,30'h5, 0,1,0);
        add(0,0,0,0,0,1,    1, 0,2,30'h5, 0,0,1);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            reset         = tbl[i].rst;
            atom_valid    = tbl[i].av;
            atom          = tbl[i].at;
            flush         = tbl[i].fl;
            end_req       = tbl[i].er;
            dct.dct_ready = tbl[i].rdy;
            @(posedge clk);
            #1;
            if (tbl[i].chk) begin
                chk(i, "dct_valid",      32'(dct.dct_valid),  32'(tbl[i].ev));
                chk(i, "dct_count",      32'(dct.dct_count),  32'(tbl[i].ec));
                chk(i, "dct_buffer",     32'(dct.dct_buffer), 32'(tbl[i].eb));
                chk(i, "overflow",       32'(overflow),       32'(tbl[i].eo));
                chk(i, "test_ending",    32'(test_ending),    32'(tbl[i].ete));
                chk(i, "test_has_ended", 32'(test_has_ended), 32'(tbl[i].ehe));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
